// File: rtl/dsky_serial_rx.sv
// 8N1 UART receiver and 5-byte frame parser feeding the AGC serial input registers.
// Frame: SYNC, id, hi, lo, chk (chk = id ^ hi ^ lo); writes {hi[6:0], lo} to register[id].
module dsky_serial_rx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx,
  output logic [14:0] dsky_verb,
  output logic [14:0] dsky_noun,
  output logic [14:0] mission_time,
  output logic [14:0] apogee,
  output logic [14:0] perigee,
  output logic        update_valid,
  output logic [2:0]  update_sel,
  output logic        frame_err
);

  localparam int             CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_LD = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0]  BIT_LD  = CW'(CLKS_PER_BIT - 1);
  localparam int             TO_LIM  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int             TW      = $clog2(TO_LIM + 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;
  typedef enum logic [2:0] {P_SYNC, P_ID, P_HI, P_LO, P_CHK} pstate_t;

  logic          rx_meta_q, rx_s_q;
  ustate_t       ust_q, ust_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          brk_q, brk_d;
  logic          strobe_q, strobe_d;
  logic          uart_ferr;

  pstate_t       pst_q, pst_d;
  logic [2:0]    id_q, id_d;
  logic [6:0]    hi_q, hi_d;
  logic [7:0]    lo_q, lo_d;
  logic [TW-1:0] to_q, to_d;
  logic [14:0]   regs_q [5];
  logic [14:0]   regs_d [5];
  logic          upd_q, upd_d;
  logic [2:0]    sel_q, sel_d;
  logic          err_q, err_d;

  // Bit timing uses down-counters; a sample is taken when the count reaches zero.
  always_comb begin
    ust_d     = ust_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    brk_d     = brk_q;
    strobe_d  = 1'b0;
    uart_ferr = 1'b0;
    case (ust_q)
      U_IDLE: begin
        if (!rx_s_q) begin
          ust_d = U_START;
          cnt_d = HALF_LD;
        end
      end
      U_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s_q) begin
          ust_d = U_IDLE;
        end else begin
          ust_d = U_DATA;
          cnt_d = BIT_LD;
          bit_d = 3'd0;
        end
      end
      U_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          sh_d  = {rx_s_q, sh_q[7:1]};
          cnt_d = BIT_LD;
          if (bit_q == 3'd7) ust_d = U_STOP;
          else               bit_d = bit_q + 3'd1;
        end
      end
      U_STOP: begin
        if (brk_q) begin
          // Line held low after a bad stop bit: wait for it to return high.
          if (rx_s_q) begin
            brk_d = 1'b0;
            ust_d = U_IDLE;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s_q) begin
          strobe_d = 1'b1;
          ust_d    = U_IDLE;
        end else begin
          uart_ferr = 1'b1;
          brk_d     = 1'b1;
        end
      end
      default: ust_d = U_IDLE;
    endcase
  end

  always_comb begin
    pst_d  = pst_q;
    id_d   = id_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    to_d   = to_q;
    regs_d = regs_q;
    upd_d  = 1'b0;
    sel_d  = sel_q;
    err_d  = 1'b0;

    if (pst_q == P_SYNC || strobe_q) begin
      to_d = '0;
    end else if (ust_q == U_IDLE) begin
      if (to_q == TW'(TO_LIM - 1)) begin
        to_d  = '0;
        err_d = 1'b1;
        pst_d = P_SYNC;
      end else begin
        to_d = to_q + TW'(1);
      end
    end

    if (strobe_q) begin
      case (pst_q)
        P_SYNC: if (sh_q == SYNC_BYTE) pst_d = P_ID;
        P_ID: begin
          id_d = sh_q[2:0];
          if (sh_q > 8'd4) begin
            err_d = 1'b1;
            pst_d = P_SYNC;
          end else begin
            pst_d = P_HI;
          end
        end
        P_HI: begin
          hi_d = sh_q[6:0];
          if (sh_q[7]) begin
            err_d = 1'b1;
            pst_d = P_SYNC;
          end else begin
            pst_d = P_LO;
          end
        end
        P_LO: begin
          lo_d  = sh_q;
          pst_d = P_CHK;
        end
        P_CHK: begin
          if (sh_q == ({5'b0, id_q} ^ {1'b0, hi_q} ^ lo_q)) begin
            for (int i = 0; i < 5; i++) begin
              if (id_q == 3'(i)) regs_d[i] = {hi_q, lo_q};
            end
            upd_d = 1'b1;
            sel_d = id_q;
          end else begin
            err_d = 1'b1;
          end
          pst_d = P_SYNC;
        end
        default: pst_d = P_SYNC;
      endcase
    end

    if (uart_ferr) begin
      err_d = 1'b1;
      pst_d = P_SYNC;
      to_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      ust_q     <= U_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      brk_q     <= 1'b0;
      strobe_q  <= 1'b0;
      pst_q     <= P_SYNC;
      id_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      to_q      <= '0;
      for (int i = 0; i < 5; i++) regs_q[i] <= '0;
      upd_q     <= 1'b0;
      sel_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      ust_q     <= ust_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      brk_q     <= brk_d;
      strobe_q  <= strobe_d;
      pst_q     <= pst_d;
      id_q      <= id_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      to_q      <= to_d;
      for (int i = 0; i < 5; i++) regs_q[i] <= regs_d[i];
      upd_q     <= upd_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
    end
  end

  assign dsky_verb    = regs_q[0];
  assign dsky_noun    = regs_q[1];
  assign mission_time = regs_q[2];
  assign apogee       = regs_q[3];
  assign perigee      = regs_q[4];
  assign update_valid = upd_q;
  assign update_sel   = sel_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_dsky_serial_rx.sv
// Bench for dsky_serial_rx: directed frame table, hand-built corner sequences and
// random frames checked against a byte-level frame model.
module tb_dsky_serial_rx;

  localparam int CPB = 16;
  localparam int TOB = 20;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx;
  logic [14:0] dsky_verb, dsky_noun, mission_time, apogee, perigee;
  logic        update_valid;
  logic [2:0]  update_sel;
  logic        frame_err;

  dsky_serial_rx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(TOB)) dut (
    .clock(clock), .reset_n(reset_n), .rx(rx),
    .dsky_verb(dsky_verb), .dsky_noun(dsky_noun), .mission_time(mission_time),
    .apogee(apogee), .perigee(perigee),
    .update_valid(update_valid), .update_sel(update_sel), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [14:0] val;
  } upd_t;

  // Frame model: bytes of the partial frame collected in a queue.
  logic [14:0] m_regs [5];
  logic [7:0]  m_q [$];
  upd_t        exp_q [$];
  int          exp_upd = 0;
  int          exp_err = 0;

  int          got_upd = 0;
  int          got_err = 0;
  int          both_hi = 0;
  logic [2:0]  last_sel;
  logic [14:0] last_val;
  upd_t        mon_e;

  function automatic logic [14:0] out_by_sel(input logic [2:0] s);
    case (s)
      3'd0: return dsky_verb;
      3'd1: return dsky_noun;
      3'd2: return mission_time;
      3'd3: return apogee;
      3'd4: return perigee;
      default: return 15'h7FFF;
    endcase
  endfunction

  always @(negedge clock) begin
    if (reset_n) begin
      if (update_valid && frame_err) both_hi++;
      if (frame_err) got_err++;
      if (update_valid) begin
        got_upd++;
        last_sel = update_sel;
        last_val = out_by_sel(update_sel);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL upd_unexpected: got sel=%0d val=0x%0h, required no update", update_sel, last_val);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.sel !== update_sel || mon_e.val !== last_val) begin
            bad++;
            $display("FAIL upd_payload: got sel=%0d val=0x%0h, required sel=%0d val=0x%0h",
                     update_sel, last_val, mon_e.sel, mon_e.val);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [14:0] v;
    if (m_q.size() == 0) begin
      if (b == 8'hA5) m_q.push_back(b);
    end else begin
      m_q.push_back(b);
      if (m_q.size() == 2 && m_q[1] > 8'd4) begin
        exp_err++;
        m_q.delete();
      end else if (m_q.size() == 3 && m_q[2][7]) begin
        exp_err++;
        m_q.delete();
      end else if (m_q.size() == 5) begin
        if (m_q[4] == (m_q[1] ^ m_q[2] ^ m_q[3])) begin
          v = {m_q[2][6:0], m_q[3]};
          m_regs[m_q[1]] = v;
          exp_upd++;
          exp_q.push_back('{sel: m_q[1][2:0], val: v});
        end else begin
          exp_err++;
        end
        m_q.delete();
      end
    end
  endtask

  task automatic model_gap(input int bits);
    if (bits > TOB + 1 && m_q.size() > 0) begin
      exp_err++;
      m_q.delete();
    end
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * CPB) @(negedge clock);
  endtask

  // Model is updated before the bits go out so the expectation is queued before the DUT pulses.
  task automatic tx(input logic [7:0] b, input logic stop_v);
    if (stop_v) model_byte(b);
    else begin
      exp_err++;
      m_q.delete();
    end
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop_v);
    rx = 1'b1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_upd_count"}, got_upd, exp_upd);
    check({tag, "_err_count"}, got_err, exp_err);
    check({tag, "_verb"}, int'(dsky_verb), int'(m_regs[0]));
    check({tag, "_noun"}, int'(dsky_noun), int'(m_regs[1]));
    check({tag, "_mtime"}, int'(mission_time), int'(m_regs[2]));
    check({tag, "_apogee"}, int'(apogee), int'(m_regs[3]));
    check({tag, "_perigee"}, int'(perigee), int'(m_regs[4]));
    check({tag, "_both_high"}, both_hi, 0);
  endtask

  typedef struct {
    int          n;
    logic [79:0] bytes;   // first byte in the most significant used position
    int          d_upd;
    int          d_err;
    logic [2:0]  sel;
    logic [14:0] val;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [79:0] by, input int du, input int de,
                              input logic [2:0] s, input logic [14:0] v);
    vec_t r;
    r.n = n; r.bytes = by; r.d_upd = du; r.d_err = de; r.sel = s; r.val = v;
    return r;
  endfunction

  vec_t tbl [9];

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, e0;
    logic [7:0] id, hi, lo, ck, by;

    tbl[0] = mk(5,  80'hA5_00_00_23_23,                1, 0, 3'd0, 15'h0023);
    tbl[1] = mk(10, 80'hA5_01_00_44_45_A5_02_7F_FF_82, 2, 0, 3'd2, 15'h7FFF);
    tbl[2] = mk(5,  80'hA5_03_00_10_00,                0, 1, 3'd3, 15'h0000);
    tbl[3] = mk(5,  80'hA5_07_00_10_17,                0, 1, 3'd3, 15'h0000);
    tbl[4] = mk(5,  80'hA5_00_80_00_80,                0, 1, 3'd0, 15'h0023);
    tbl[5] = mk(5,  80'hA5_00_00_A5_A5,                1, 0, 3'd0, 15'h00A5);
    tbl[6] = mk(6,  80'h12_A5_03_12_34_25,             1, 0, 3'd3, 15'h1234);
    tbl[7] = mk(5,  80'hA5_03_12_34_25,                1, 0, 3'd3, 15'h1234);
    tbl[8] = mk(5,  80'hA5_01_00_44_45,                1, 0, 3'd1, 15'h0044);

    for (int i = 0; i < 5; i++) m_regs[i] = '0;
    rx = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    repeat (1000) @(negedge clock);
    check_all("reset_idle");
    check("reset_sel", int'(update_sel), 0);

    for (int i = 0; i < 9; i++) begin
      u0 = got_upd;
      e0 = got_err;
      for (int j = 0; j < tbl[i].n; j++) begin
        by = tbl[i].bytes[8*(tbl[i].n-1-j) +: 8];
        tx(by, 1'b1);
      end
      idle(3);
      check($sformatf("tbl%0d_upd", i), got_upd - u0, tbl[i].d_upd);
      check($sformatf("tbl%0d_err", i), got_err - e0, tbl[i].d_err);
      check($sformatf("tbl%0d_reg", i), int'(out_by_sel(tbl[i].sel)), int'(tbl[i].val));
      if (tbl[i].d_upd > 0) begin
        check($sformatf("tbl%0d_last_sel", i), int'(last_sel), int'(tbl[i].sel));
        check($sformatf("tbl%0d_last_val", i), int'(last_val), int'(tbl[i].val));
      end
    end
    check_all("table");

    // Bad stop bit in the middle of a frame, then a good frame.
    u0 = got_upd; e0 = got_err;
    tx(8'hA5, 1'b1);
    tx(8'h00, 1'b0);
    idle(2);
    tx(8'hA5, 1'b1); tx(8'h04, 1'b1); tx(8'h01, 1'b1); tx(8'h02, 1'b1); tx(8'h07, 1'b1);
    idle(3);
    check("stopbit_err", got_err - e0, 1);
    check("stopbit_upd", got_upd - u0, 1);
    check("stopbit_perigee", int'(perigee), 16'h0102);
    check_all("stopbit");

    // Inter-byte timeout; trailing bytes land in the sync hunt and are dropped.
    u0 = got_upd; e0 = got_err;
    tx(8'hA5, 1'b1); tx(8'h00, 1'b1);
    idle(25);
    model_gap(25);
    tx(8'h00, 1'b1); tx(8'h23, 1'b1); tx(8'h23, 1'b1);
    idle(3);
    check("timeout_err", got_err - e0, 1);
    check("timeout_upd", got_upd - u0, 0);
    check_all("timeout");

    // Short low glitch between bytes of a frame must not produce a byte.
    u0 = got_upd; e0 = got_err;
    tx(8'hA5, 1'b1);
    rx = 1'b0;
    repeat (5) @(negedge clock);
    idle(1);
    tx(8'h00, 1'b1); tx(8'h00, 1'b1); tx(8'h23, 1'b1); tx(8'h23, 1'b1);
    idle(3);
    check("glitch_err", got_err - e0, 0);
    check("glitch_upd", got_upd - u0, 1);
    check("glitch_verb", int'(dsky_verb), 16'h0023);

    // Random frames, some with a bad id, hi[7] or checksum.
    for (int k = 0; k < 30; k++) begin
      id = 8'($urandom_range(0, 5));
      hi = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) != 0) hi[7] = 1'b0;
      lo = 8'($urandom_range(0, 255));
      ck = id ^ hi ^ lo;
      if ($urandom_range(0, 5) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      tx(8'hA5, 1'b1); tx(id, 1'b1); tx(hi, 1'b1); tx(lo, 1'b1); tx(ck, 1'b1);
      idle(2);
    end
    idle(25);
    model_gap(25);
    check_all("random");

    // Reset in the middle of a data byte of a valid frame.
    tx(8'hA5, 1'b1);
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b0);
    repeat (CPB / 2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) m_regs[i] = '0;
    m_q.delete();
    check("rst_verb", int'(dsky_verb), 0);
    check("rst_noun", int'(dsky_noun), 0);
    check("rst_mtime", int'(mission_time), 0);
    check("rst_apogee", int'(apogee), 0);
    check("rst_perigee", int'(perigee), 0);
    check("rst_valid", int'(update_valid), 0);
    check("rst_err", int'(frame_err), 0);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    idle(2);
    check_all("post_reset_idle");
    tx(8'hA5, 1'b1); tx(8'h00, 1'b1); tx(8'h00, 1'b1); tx(8'h23, 1'b1); tx(8'h23, 1'b1);
    idle(3);
    check("post_reset_verb", int'(dsky_verb), 16'h0023);
    check_all("post_reset");
    check("exp_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
